// File: rtl/solve_sequencer.sv
// rtl/solve_sequencer.sv - Jacobi solve sequencer: raster read addresses, delayed write addresses, done handshake
// Reads and writes ping-pong between two phi banks; a PIPE_LAT-deep delay line turns each read into its write.
module solve_sequencer #(
  parameter int NX       = 64,
  parameter int NY       = 64,
  parameter int NITER    = 16,
  parameter int PIPE_LAT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_solve,
  output logic                       solve_done,
  output logic                       busy,
  output logic                       rd_valid,
  output logic [$clog2(NX)-1:0]      rd_x,
  output logic [$clog2(NY)-1:0]      rd_y,
  output logic                       rd_bank,
  output logic                       wr_valid,
  output logic [$clog2(NX)-1:0]      wr_x,
  output logic [$clog2(NY)-1:0]      wr_y,
  output logic                       wr_bank,
  output logic                       wr_boundary,
  output logic [$clog2(NITER+1)-1:0] iter,
  output logic                       result_bank
);

  localparam int XW = $clog2(NX);
  localparam int YW = $clog2(NY);
  localparam int IW = $clog2(NITER + 1);
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int DW = XW + YW + 3;

  localparam logic [XW-1:0] XMAX = XW'(NX - 1);
  localparam logic [YW-1:0] YMAX = YW'(NY - 1);
  localparam logic [IW-1:0] IMAX = IW'(NITER - 1);
  localparam logic [CW-1:0] CMAX = CW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bank_q, bank_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      iter_q  <= '0;
      cnt_q   <= '0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      iter_q  <= iter_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    iter_d  = iter_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    case (state_q)
      S_IDLE: begin
        x_d    = '0;
        y_d    = '0;
        iter_d = '0;
        cnt_d  = '0;
        bank_d = 1'b0;
        if (start_solve) state_d = S_SWEEP;
      end
      S_SWEEP: begin
        if (x_q == XMAX) begin
          x_d = '0;
          if (y_q == YMAX) begin
            y_d     = '0;
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Hold reads off until every write of this sweep has left the delay line.
        if (cnt_q == CMAX) begin
          if (iter_q != IMAX) begin
            iter_d  = iter_q + 1'b1;
            bank_d  = ~bank_q;
            state_d = S_SWEEP;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_RELEASE;
      S_RELEASE: begin
        if (!start_solve) begin
          iter_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic          rd_boundary;
  logic [DW-1:0] dl_in;
  logic [DW-1:0] dl_q [PIPE_LAT];

  assign rd_boundary = (x_q == '0) | (x_q == XMAX) | (y_q == '0) | (y_q == YMAX);
  assign dl_in       = rd_valid ? {1'b1, x_q, y_q, ~bank_q, rd_boundary} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= dl_in;
      for (int i = 1; i < PIPE_LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign {wr_valid, wr_x, wr_y, wr_bank, wr_boundary} = dl_q[PIPE_LAT-1];

  assign rd_valid    = (state_q == S_SWEEP);
  assign solve_done  = (state_q == S_DONE);
  assign busy        = (state_q == S_SWEEP) | (state_q == S_DRAIN) | (state_q == S_DONE);
  assign rd_x        = x_q;
  assign rd_y        = y_q;
  assign rd_bank     = bank_q;
  assign iter        = iter_q;
  assign result_bank = 1'(NITER % 2);

endmodule

// File: tb/tb_solve_sequencer.sv
// tb/tb_solve_sequencer.sv - self-checking bench for solve_sequencer over three grid configurations
module tb_solve_sequencer;

  logic clk;
  logic st [3];
  logic rs [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Per-DUT configuration: 0 = 4x4/2 sweeps/lat 3, 1 = 4x4/3 sweeps/lat 3, 2 = 2x2/1 sweep/lat 1
  int cnx  [3] = '{4, 4, 2};
  int cny  [3] = '{4, 4, 2};
  int cnit [3] = '{2, 3, 1};
  int clat [3] = '{3, 3, 1};

  // Model: phase 0 idle, 1 solving (tt = cycles since request sampled), 2 waiting for release
  int ph [3];
  int tt [3];

  logic       a_done, a_busy, a_rv, a_rb, a_wv, a_wb, a_wbd, a_resb;
  logic [1:0] a_rx, a_ry, a_wx, a_wy, a_it;
  logic       b_done, b_busy, b_rv, b_rb, b_wv, b_wb, b_wbd, b_resb;
  logic [1:0] b_rx, b_ry, b_wx, b_wy, b_it;
  logic       c_done, c_busy, c_rv, c_rb, c_wv, c_wb, c_wbd, c_resb;
  logic       c_rx, c_ry, c_wx, c_wy, c_it;

  solve_sequencer #(.NX(4), .NY(4), .NITER(2), .PIPE_LAT(3)) dut_a (
    .clk(clk), .rst(rs[0]), .start_solve(st[0]), .solve_done(a_done), .busy(a_busy),
    .rd_valid(a_rv), .rd_x(a_rx), .rd_y(a_ry), .rd_bank(a_rb),
    .wr_valid(a_wv), .wr_x(a_wx), .wr_y(a_wy), .wr_bank(a_wb), .wr_boundary(a_wbd),
    .iter(a_it), .result_bank(a_resb));

  solve_sequencer #(.NX(4), .NY(4), .NITER(3), .PIPE_LAT(3)) dut_b (
    .clk(clk), .rst(rs[1]), .start_solve(st[1]), .solve_done(b_done), .busy(b_busy),
    .rd_valid(b_rv), .rd_x(b_rx), .rd_y(b_ry), .rd_bank(b_rb),
    .wr_valid(b_wv), .wr_x(b_wx), .wr_y(b_wy), .wr_bank(b_wb), .wr_boundary(b_wbd),
    .iter(b_it), .result_bank(b_resb));

  solve_sequencer #(.NX(2), .NY(2), .NITER(1), .PIPE_LAT(1)) dut_c (
    .clk(clk), .rst(rs[2]), .start_solve(st[2]), .solve_done(c_done), .busy(c_busy),
    .rd_valid(c_rv), .rd_x(c_rx), .rd_y(c_ry), .rd_bank(c_rb),
    .wr_valid(c_wv), .wr_x(c_wx), .wr_y(c_wy), .wr_bank(c_wb), .wr_boundary(c_wbd),
    .iter(c_it), .result_bank(c_resb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    for (int id = 0; id < 3; id++) begin
      int d;
      d = cnit[id] * (cnx[id] * cny[id] + clat[id]) + 1;
      if (rs[id]) begin
        ph[id] = 0;
        tt[id] = 0;
      end else begin
        case (ph[id])
          0: if (st[id]) begin ph[id] = 1; tt[id] = 1; end
          1: if (tt[id] == d) ph[id] = 2; else tt[id]++;
          default: if (!st[id]) ph[id] = 0;
        endcase
      end
    end
  endtask

  task automatic check_dut(input int id, input int done, input int bsy, input int rv, input int rx,
                           input int ry, input int rb, input int wv, input int wx, input int wy,
                           input int wb, input int wbd, input int it, input int resb);
    int nx, ny, nn, p, d, u, k, r, w, e_rv, e_wv, ex, ey;
    string pf;
    nx = cnx[id];
    ny = cny[id];
    nn = nx * ny;
    p  = nn + clat[id];
    d  = cnit[id] * p + 1;
    pf = $sformatf("dut%0d_", id);
    e_rv = 0;
    e_wv = 0;
    chk({pf, "solve_done"}, done, (ph[id] == 1 && tt[id] == d) ? 1 : 0);
    chk({pf, "busy"}, bsy, (ph[id] == 1) ? 1 : 0);
    chk({pf, "result_bank"}, resb, cnit[id] % 2);
    if (ph[id] == 0) chk({pf, "iter_idle"}, it, 0);
    if (ph[id] == 1) begin
      u = tt[id] - 1;
      k = u / p;
      r = u % p;
      chk({pf, "iter"}, it, (k < cnit[id]) ? k : cnit[id] - 1);
      if (k < cnit[id] && r < nn) begin
        e_rv = 1;
        chk({pf, "rd_x"}, rx, r % nx);
        chk({pf, "rd_y"}, ry, r / nx);
        chk({pf, "rd_bank"}, rb, k % 2);
      end
      w = u - clat[id];
      if (w >= 0 && w / p < cnit[id] && w % p < nn) begin
        e_wv = 1;
        ex = (w % p) % nx;
        ey = (w % p) / nx;
        chk({pf, "wr_x"}, wx, ex);
        chk({pf, "wr_y"}, wy, ey);
        chk({pf, "wr_bank"}, wb, (w / p + 1) % 2);
        chk({pf, "wr_boundary"}, wbd, (ex == 0 || ex == nx - 1 || ey == 0 || ey == ny - 1) ? 1 : 0);
      end
    end
    chk({pf, "rd_valid"}, rv, e_rv);
    chk({pf, "wr_valid"}, wv, e_wv);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check_dut(0, int'(a_done), int'(a_busy), int'(a_rv), int'(a_rx), int'(a_ry), int'(a_rb), int'(a_wv),
              int'(a_wx), int'(a_wy), int'(a_wb), int'(a_wbd), int'(a_it), int'(a_resb));
    check_dut(1, int'(b_done), int'(b_busy), int'(b_rv), int'(b_rx), int'(b_ry), int'(b_rb), int'(b_wv),
              int'(b_wx), int'(b_wy), int'(b_wb), int'(b_wbd), int'(b_it), int'(b_resb));
    check_dut(2, int'(c_done), int'(c_busy), int'(c_rv), int'(c_rx), int'(c_ry), int'(c_rb), int'(c_wv),
              int'(c_wx), int'(c_wy), int'(c_wb), int'(c_wbd), int'(c_it), int'(c_resb));
  endtask

  initial begin
    int n, rdc, wrc, inc, cnt, dn;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      rs[i] = 1'b1;
      ph[i] = 0;
      tt[i] = 0;
    end
    tick();
    tick();
    chk("reset_busy", int'(a_busy), 0);
    chk("reset_rd_valid", int'(a_rv), 0);
    chk("reset_wr_valid", int'(a_wv), 0);
    chk("reset_iter", int'(a_it), 0);
    for (int i = 0; i < 3; i++) rs[i] = 1'b0;
    tick();

    // Config A: basic timing, addresses, banks
    st[0] = 1'b1;
    n = 0; rdc = 0; wrc = 0; inc = 0;
    while (!a_done && n < 200) begin
      tick();
      n++;
      rdc += int'(a_rv);
      wrc += int'(a_wv);
      inc += int'(a_wv & ~a_wbd);
      if (n == 1)  begin chk("a_c1_rv", int'(a_rv), 1); chk("a_c1_rx", int'(a_rx), 0); chk("a_c1_rb", int'(a_rb), 0); end
      if (n == 4)  begin chk("a_c4_wv", int'(a_wv), 1); chk("a_c4_wb", int'(a_wb), 1); chk("a_c4_wbd", int'(a_wbd), 1); end
      if (n == 9)  begin chk("a_c9_wx", int'(a_wx), 1); chk("a_c9_wy", int'(a_wy), 1); chk("a_c9_wbd", int'(a_wbd), 0); end
      if (n == 17) chk("a_c17_rv", int'(a_rv), 0);
      if (n == 20) begin chk("a_c20_rv", int'(a_rv), 1); chk("a_c20_rb", int'(a_rb), 1); end
      if (n == 23) chk("a_c23_wb", int'(a_wb), 0);
      if (n == 38) begin chk("a_c38_wv", int'(a_wv), 1); chk("a_c38_wx", int'(a_wx), 3); chk("a_c38_wy", int'(a_wy), 3); end
    end
    chk("a_done_cycle", n, 39);
    chk("a_read_count", rdc, 32);
    chk("a_write_count", wrc, 32);
    chk("a_interior_writes", inc, 8);
    chk("a_result_bank", int'(a_resb), 0);

    // Start held after done: no new solve
    cnt = 0; dn = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt += int'(a_rv);
      dn  += int'(a_done);
    end
    chk("a_hold_reads", cnt, 0);
    chk("a_hold_done", dn, 0);
    st[0] = 1'b0;
    tick();
    tick();
    st[0] = 1'b1;
    tick();
    chk("a_restart_rv", int'(a_rv), 1);
    chk("a_restart_rx", int'(a_rx), 0);
    chk("a_restart_ry", int'(a_ry), 0);
    chk("a_restart_rb", int'(a_rb), 0);

    // Reset sampled at the end of cycle 10
    for (int i = 2; i <= 10; i++) tick();
    rs[0] = 1'b1;
    tick();
    chk("a_rst_rv", int'(a_rv), 0);
    chk("a_rst_wv", int'(a_wv), 0);
    chk("a_rst_iter", int'(a_it), 0);
    rs[0] = 1'b0;
    n = 0; wrc = 0;
    while (!a_done && n < 200) begin
      tick();
      n++;
      if (n <= 3) wrc += int'(a_wv);
    end
    chk("a_rst_no_stale_writes", wrc, 0);
    chk("a_rst_done_cycle", n, 39);
    st[0] = 1'b0;
    tick();
    tick();

    // Config B: odd sweep count
    st[1] = 1'b1;
    n = 0;
    while (!b_done && n < 200) begin
      tick();
      n++;
      if (n == 57) begin chk("b_c57_wv", int'(b_wv), 1); chk("b_c57_wb", int'(b_wb), 1); end
    end
    chk("b_done_cycle", n, 58);
    chk("b_result_bank", int'(b_resb), 1);
    st[1] = 1'b0;
    tick();
    tick();

    // Config C: minimal grid
    st[2] = 1'b1;
    n = 0; rdc = 0; wrc = 0; inc = 0;
    while (!c_done && n < 200) begin
      tick();
      n++;
      rdc += int'(c_rv);
      wrc += int'(c_wv);
      inc += int'(c_wv & c_wbd);
      if (n == 1) chk("c_c1_wv", int'(c_wv), 0);
      if (n == 5) chk("c_c5_wv", int'(c_wv), 1);
    end
    chk("c_done_cycle", n, 6);
    chk("c_read_count", rdc, 4);
    chk("c_write_count", wrc, 4);
    chk("c_boundary_writes", inc, 4);
    st[2] = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/solve_sequencer.md
Name: solve_sequencer

Overview:
- Responder side of the controller's solve handshake.
- Takes the level-held start_solve request and runs NITER Jacobi sweeps over the NX x NY potential grid, with ping-pong banks. Each sweep issues one stencil read address per cycle to the external stencil datapath, and a matching write address PIPE_LAT cycles later.
- Returns a one-cycle solve_done once the final sweep's last write has been issued.

Parameters:
- NX, 64, grid width in cells (>=2)
- NY, 64, grid height in cells (>=2)
- NITER, 16, Jacobi sweeps per solve (>=1)
- PIPE_LAT, 4, stencil datapath latency in cycles, read address to write data (>=1)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start_solve  input  1  solve request from controller; level, held until solve_done is seen
- solve_done  output  1  one-cycle pulse: all writes of the final sweep issued
- busy  output  1  high from the cycle after start is accepted through the solve_done cycle
- rd_valid  output  1  read address valid
- rd_x  output  $clog2(NX)  read cell column
- rd_y  output  $clog2(NY)  read cell row
- rd_bank  output  1  bank to read phi from; rho uses the same address
- wr_valid  output  1  write strobe for datapath result
- wr_x  output  $clog2(NX)  write cell column
- wr_y  output  $clog2(NY)  write cell row
- wr_bank  output  1  bank to write
- wr_boundary  output  1  write cell is on grid edge; datapath writes 0 (Dirichlet)
- iter  output  $clog2(NITER+1)  current sweep index
- result_bank  output  1  constant NITER%2: bank holding the final phi

Behaviour:
- Reset values: state IDLE. solve_done, busy, rd_valid, wr_valid, wr_boundary, rd_x, rd_y, wr_x, wr_y, rd_bank, wr_bank and iter are all 0. Delay line is cleared.
- States: IDLE, SWEEP, DRAIN, DONE, RELEASE.
- IDLE: start_solve sampled high -> SWEEP, with x=y=0, iter=0, bank=0.
- SWEEP:
  - rd_valid=1 every cycle.
  - Raster order, x fastest: (0,0), (1,0) … (NX-1,0), (0,1) … (NX-1,NY-1).
  - Exactly NX*NY read cycles, no bubbles.
  - After (NX-1,NY-1) -> DRAIN.
- DRAIN: rd_valid=0 for PIPE_LAT cycles, then:
  - if iter<NITER-1: iter+1, bank toggles, -> SWEEP (back-to-back, no idle cycle);
  - else -> DONE.
- DONE: solve_done=1 for exactly one cycle -> RELEASE.
- RELEASE: stays until start_solve sampled low -> IDLE.
  - A start_solve still high is never re-accepted as a new request.
- Bank rule: sweep k reads bank k%2 and writes bank (k+1)%2, so wr_bank = ~rd_bank of the originating read.
- Write side: a PIPE_LAT-deep shift register carries {valid, x, y, bank, boundary}.
  - wr_* equals the rd_* of exactly PIPE_LAT cycles earlier.
  - The writes of one sweep complete inside its DRAIN window, before the next sweep's first read.
- Boundary: wr_boundary = (x==0 | x==NX-1 | y==0 | y==NY-1) of that write cell.
- Timing, with start sampled at cycle 0 and N=NX*NY, L=PIPE_LAT:
  - sweep k reads in cycles k(N+L)+1 .. k(N+L)+N;
  - last write of the solve at cycle NITER(N+L);
  - solve_done at cycle NITER(N+L)+1.
- Counter wrap: x wraps NX-1 -> 0 with a y increment. y never wraps inside a sweep. iter saturates at NITER-1 during the solve and clears to 0 on IDLE entry.
- start_solve deasserting mid-solve is ignored; the solve completes and solve_done still pulses.
- Reset mid-operation:
  - outputs return to reset values the next cycle;
  - in-flight delay-line writes are discarded (no wr_valid after reset);
  - a start_solve high at the reset release cycle is accepted from IDLE normally.

Test Plan:
- Basic timing, with NX=4, NY=4, NITER=2, PIPE_LAT=3; start_solve high at cycle 0 and held:
  - rd_valid in cycles 1-16 and 20-35;
  - wr_valid in cycles 4-19 and 23-38;
  - solve_done only at cycle 39;
  - result_bank=0.
- Address and bank check, same config: sweep 0 reads (0,0)..(3,3) in raster order from bank 0 and writes bank 1 with identical coordinates 3 cycles later. wr_boundary is 0 only for (1,1), (2,1), (1,2), (2,2). Sweep 1 reads bank 1 and writes bank 0.
- Handshake release: hold start_solve high for 5 cycles after solve_done -> no rd_valid or second solve_done. Drop start_solve, re-raise it 2 cycles later -> a new solve starts, first read (0,0) bank 0 one cycle after the request is sampled.
- Odd NITER=3: result_bank=1; the last sweep writes bank 1; solve_done at cycle 3*19+1=58.
- Reset mid-sweep at cycle 10: from cycle 11, rd_valid=wr_valid=0 and iter=0, with no writes from pending reads. Restart completes with solve_done at 39 cycles after the new request is sampled.
- Minimal grid NX=2, NY=2, PIPE_LAT=1, NITER=1:
  - reads cycles 1-4, writes 2-5, all flagged boundary;
  - solve_done at cycle 6.
